// File: rtl/spi_slave_regs.sv
// spi_slave_regs: SPI responder with a small register file. Frames are 8 LSB-first address bits, idle gap, then data.
// Defining SPI_SLV_ERR_CNT_EN adds a saturating decode-error/abort counter on err_cnt_o.
module spi_slave_regs #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_REGS    = 8,
    parameter int GAP_CYCLES  = 4,
    parameter int TAIL_CYCLES = 6
) (
    input  logic                           pclk_i,
    input  logic                           prst_i,
    input  logic                           sclk_i,
    input  logic                           ss_i,
    input  logic                           mosi_i,
    output logic                           miso_o,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic                           wr_pulse_o,
    output logic [2:0]                     wr_addr_o,
    output logic                           busy_o,
    output logic                           decode_err_o,
    output logic [7:0]                     err_cnt_o
);

    localparam logic [4:0] S_IDLE = 5'b00001;
    localparam logic [4:0] S_ADDR = 5'b00010;
    localparam logic [4:0] S_GAP  = 5'b00100;
    localparam logic [4:0] S_DATA = 5'b01000;
    localparam logic [4:0] S_TAIL = 5'b10000;

    localparam logic [7:0] ADDR_LAST = 8'd7;
    localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);
    localparam logic [7:0] DATA_LAST = 8'(DATA_WIDTH - 1);
    localparam logic [7:0] TAIL_LAST = 8'(TAIL_CYCLES - 1);

    logic [2:0]            sclk_sync;
    logic [2:0]            ss_sync;
    logic [1:0]            mosi_sync;
    logic [4:0]            state;
    logic [7:0]            cnt;
    logic [7:0]            addr_q;
    logic [DATA_WIDTH-1:0] wdat_q;
    logic [DATA_WIDTH-1:0] shift_rd;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    logic                  fall;
    logic                  ss_fall;
    logic                  ss_rise;
    logic                  mosi_bit;
    logic [7:0]            addr_full;
    logic [DATA_WIDTH-1:0] wdat_full;
    logic                  addr_legal;
    logic                  dec_err_ev;

    // Stage [1] is the second synchroniser flop; stage [2] only serves edge detection.
    assign fall       = sclk_sync[2] & ~sclk_sync[1];
    assign ss_fall    = ss_sync[2] & ~ss_sync[1];
    assign ss_rise    = ~ss_sync[2] & ss_sync[1];
    assign mosi_bit   = mosi_sync[1];
    assign addr_full  = {mosi_bit, addr_q[7:1]};
    assign wdat_full  = {mosi_bit, wdat_q[DATA_WIDTH-1:1]};
    assign addr_legal = (addr_full[6:3] == 4'd0);
    assign dec_err_ev = (state == S_ADDR) && fall && (cnt == ADDR_LAST) && !addr_legal;
    assign busy_o     = (state != S_IDLE);

    always_comb begin
        regs_o = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            regs_o[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[k];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
        end else begin
            sclk_sync <= {sclk_sync[1:0], sclk_i};
            ss_sync   <= {ss_sync[1:0], ss_i};
            mosi_sync <= {mosi_sync[0], mosi_i};
        end
    end

    // NOTE: the register file is small and flop-based, so it is cleared by reset like any other state.
    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) begin
            state        <= S_IDLE;
            cnt          <= '0;
            addr_q       <= '0;
            wdat_q       <= '0;
            shift_rd     <= '0;
            miso_o       <= 1'b1;
            wr_pulse_o   <= 1'b0;
            wr_addr_o    <= '0;
            decode_err_o <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
        end else begin
            wr_pulse_o   <= 1'b0;
            decode_err_o <= dec_err_ev;
            case (state)
                S_IDLE: begin
                    if (ss_fall) begin
                        state <= S_ADDR;
                        cnt   <= '0;
                    end
                end
                S_ADDR: begin
                    if (fall) begin
                        addr_q <= addr_full;
                        if (cnt == ADDR_LAST) begin
                            cnt      <= '0;
                            state    <= S_GAP;
                            shift_rd <= addr_legal ? regs_q[addr_full[2:0]] : '0;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                S_GAP: begin
                    if (fall) begin
                        if (cnt == GAP_LAST) begin
                            cnt   <= '0;
                            state <= S_DATA;
                            if (!addr_q[7]) miso_o <= shift_rd[0];
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (fall) begin
                        wdat_q <= wdat_full;
                        if (!addr_q[7]) begin
                            miso_o   <= (cnt == DATA_LAST) ? 1'b1 : shift_rd[1];
                            shift_rd <= {1'b1, shift_rd[DATA_WIDTH-1:1]};
                        end
                        if (cnt == DATA_LAST) begin
                            cnt   <= '0;
                            state <= S_TAIL;
                            if (addr_q[7] && (addr_q[6:3] == 4'd0)) begin
                                regs_q[addr_q[2:0]] <= wdat_full;
                                wr_pulse_o          <= 1'b1;
                                wr_addr_o           <= addr_q[2:0];
                            end
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                S_TAIL: begin
                    if (fall) begin
                        if (cnt == TAIL_LAST) begin
                            cnt   <= '0;
                            state <= S_ADDR;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
            // Deselect wins over any sclk work in the same cycle; a commit above still lands.
            if (ss_rise && (state != S_IDLE)) begin
                state  <= S_IDLE;
                cnt    <= '0;
                miso_o <= 1'b1;
            end
        end
    end

`ifdef SPI_SLV_ERR_CNT_EN
    logic       abort_ev;
    logic [7:0] err_cnt_q;

    assign abort_ev = ss_rise && !((state == S_IDLE) || (state == S_TAIL) ||
                                   ((state == S_ADDR) && (cnt == 8'd0)));

    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) begin
            err_cnt_q <= '0;
        end else if ((abort_ev || dec_err_ev) && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_spi_slave_regs.sv
// Self-checking bench for spi_slave_regs: table vectors, hand-written frame sequences and random traffic.
module tb_spi_slave_regs;

    logic        pclk_i = 1'b0;
    logic        prst_i = 1'b0;
    logic        sclk_i = 1'b0;
    logic        ss_i   = 1'b1;
    logic        mosi_i = 1'b0;
    logic        miso_o;
    logic [63:0] regs_o;
    logic        wr_pulse_o;
    logic [2:0]  wr_addr_o;
    logic        busy_o;
    logic        decode_err_o;
    logic [7:0]  err_cnt_o;

    spi_slave_regs dut (
        .pclk_i       (pclk_i),
        .prst_i       (prst_i),
        .sclk_i       (sclk_i),
        .ss_i         (ss_i),
        .mosi_i       (mosi_i),
        .miso_o       (miso_o),
        .regs_o       (regs_o),
        .wr_pulse_o   (wr_pulse_o),
        .wr_addr_o    (wr_addr_o),
        .busy_o       (busy_o),
        .decode_err_o (decode_err_o),
        .err_cnt_o    (err_cnt_o)
    );

    always #5 pclk_i = ~pclk_i;

    int n_cmp  = 0;
    int n_fail = 0;
    int wr_hi  = 0;
    int derr_hi = 0;

    // Reference model: what the register file and counters should hold.
    logic [7:0] ref_regs [8];
    logic [2:0] ref_wr_addr;
    int         ref_err;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp_rd;
        int         exp_wr;
        int         exp_derr;
    } vec_t;

    always @(negedge pclk_i) begin
        if (wr_pulse_o) wr_hi++;
        if (decode_err_o) derr_hi++;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic ref_reset();
        for (int k = 0; k < 8; k++) ref_regs[k] = 8'h00;
        ref_wr_addr = 3'd0;
        ref_err     = 0;
    endtask

    task automatic ref_err_inc();
        if (ref_err < 255) ref_err++;
    endtask

    task automatic model_txn(input logic [7:0] addr, input logic [7:0] data,
                             output logic [7:0] exp_rd, output int exp_wr, output int exp_derr);
        bit legal;
        legal    = (addr[6:3] == 4'd0);
        exp_derr = legal ? 0 : 1;
        exp_wr   = 0;
        exp_rd   = 8'hFF;
        if (!legal) ref_err_inc();
        if (addr[7]) begin
            if (legal) begin
                ref_regs[addr[2:0]] = data;
                ref_wr_addr         = addr[2:0];
                exp_wr              = 1;
            end
        end else begin
            exp_rd = legal ? ref_regs[addr[2:0]] : 8'h00;
        end
    endtask

    function automatic int exp_err_cnt();
`ifdef SPI_SLV_ERR_CNT_EN
        return ref_err;
`else
        return 0;
`endif
    endfunction

    // One sclk period: controller samples MISO and drives MOSI on the rise.
    task automatic sclk_bit(input logic mo, output logic mi);
        @(negedge pclk_i);
        mi     = miso_o;
        sclk_i = 1'b1;
        mosi_i = mo;
        repeat (8) @(negedge pclk_i);
        sclk_i = 1'b0;
        repeat (8) @(negedge pclk_i);
    endtask

    task automatic frame_open();
        @(negedge pclk_i);
        ss_i = 1'b0;
        repeat (6) @(negedge pclk_i);
    endtask

    task automatic frame_close();
        @(negedge pclk_i);
        ss_i = 1'b1;
        repeat (6) @(negedge pclk_i);
    endtask

    task automatic txn(input logic [7:0] addr, input logic [7:0] data, input int n_data,
                       input bit tail, output logic [7:0] rd, output logic miso_end);
        logic b;
        rd = 8'h00;
        for (int i = 0; i < 8; i++) sclk_bit(addr[i], b);
        for (int i = 0; i < 4; i++) sclk_bit(1'b0, b);
        for (int i = 0; i < n_data; i++) begin
            sclk_bit(data[i], b);
            rd[i] = b;
        end
        miso_end = miso_o;
        if (tail) for (int i = 0; i < 6; i++) sclk_bit(1'b0, b);
    endtask

    task automatic run_txn(input logic [7:0] addr, input logic [7:0] data, input bit tail,
                           output logic [7:0] rd, output int nwr, output int nderr,
                           output logic miso_end);
        int w0, d0;
        w0 = wr_hi;
        d0 = derr_hi;
        txn(addr, data, 8, tail, rd, miso_end);
        nwr   = wr_hi - w0;
        nderr = derr_hi - d0;
    endtask

    task automatic check_state(input string tag);
        for (int k = 0; k < 8; k++)
            check($sformatf("%s reg%0d", tag, k), 64'(regs_o[k*8 +: 8]), 64'(ref_regs[k]));
        check({tag, " wr_addr"}, 64'(wr_addr_o), 64'(ref_wr_addr));
        check({tag, " err_cnt"}, 64'(err_cnt_o), 64'(exp_err_cnt()));
    endtask

    task automatic model_checked_txn(input string tag, input logic [7:0] addr,
                                     input logic [7:0] data, input bit tail);
        logic [7:0] rd, exp_rd;
        logic       miso_end;
        int         nwr, nderr, exp_wr, exp_derr;
        run_txn(addr, data, tail, rd, nwr, nderr, miso_end);
        model_txn(addr, data, exp_rd, exp_wr, exp_derr);
        check({tag, " miso data"}, 64'(rd), 64'(exp_rd));
        check({tag, " miso idle"}, 64'(miso_end), 64'd1);
        check({tag, " wr pulses"}, 64'(nwr), 64'(exp_wr));
        check({tag, " derr pulses"}, 64'(nderr), 64'(exp_derr));
        check_state(tag);
    endtask

    initial begin
        vec_t       tab [10];
        logic [7:0] rd, exp_rd, a, d;
        logic       miso_end;
        int         nwr, nderr, exp_wr, exp_derr, w0, n_txn;

        tab[0] = '{8'h83, 8'hA5, 8'hFF, 1, 0};
        tab[1] = '{8'h03, 8'h00, 8'hA5, 0, 0};
        tab[2] = '{8'h84, 8'h3C, 8'hFF, 1, 0};
        tab[3] = '{8'h85, 8'hC3, 8'hFF, 1, 0};
        tab[4] = '{8'h04, 8'h00, 8'h3C, 0, 0};
        tab[5] = '{8'h05, 8'h00, 8'hC3, 0, 0};
        tab[6] = '{8'h9F, 8'hFF, 8'hFF, 0, 1};
        tab[7] = '{8'h1B, 8'h00, 8'h00, 0, 1};
        tab[8] = '{8'h03, 8'h00, 8'hA5, 0, 0};
        tab[9] = '{8'h07, 8'h00, 8'h00, 0, 0};

        ref_reset();
        repeat (3) @(negedge pclk_i);
        check("reset miso", 64'(miso_o), 64'd1);
        check("reset busy", 64'(busy_o), 64'd0);
        check("reset wr_pulse", 64'(wr_pulse_o), 64'd0);
        check("reset decode_err", 64'(decode_err_o), 64'd0);
        prst_i = 1'b1;
        repeat (3) @(negedge pclk_i);
        check_state("reset");

        // Single-transaction frames from the table.
        for (int i = 0; i < 10; i++) begin
            frame_open();
            check($sformatf("vec%0d busy", i), 64'(busy_o), 64'd1);
            run_txn(tab[i].addr, tab[i].data, 1'b0, rd, nwr, nderr, miso_end);
            model_txn(tab[i].addr, tab[i].data, exp_rd, exp_wr, exp_derr);
            check($sformatf("vec%0d miso data", i), 64'(rd), 64'(tab[i].exp_rd));
            check($sformatf("vec%0d miso idle", i), 64'(miso_end), 64'd1);
            check($sformatf("vec%0d wr pulses", i), 64'(nwr), 64'(tab[i].exp_wr));
            check($sformatf("vec%0d derr pulses", i), 64'(nderr), 64'(tab[i].exp_derr));
            frame_close();
            check($sformatf("vec%0d busy after", i), 64'(busy_o), 64'd0);
            check_state($sformatf("vec%0d", i));
        end

        // Burst: three transactions with ss_i held low, separated by tail cycles.
        w0 = wr_hi;
        frame_open();
        model_checked_txn("burst0", 8'h80, 8'h11, 1'b1);
        model_checked_txn("burst1", 8'h81, 8'h22, 1'b1);
        model_checked_txn("burst2", 8'h00, 8'h00, 1'b0);
        frame_close();
        check("burst total wr pulses", 64'(wr_hi - w0), 64'd2);
        check("burst reg0", 64'(regs_o[7:0]), 64'h11);
        check("burst reg1", 64'(regs_o[15:8]), 64'h22);

        // Abort after 5 data bits: the write is discarded and counted as an error.
        w0 = wr_hi;
        frame_open();
        txn(8'h82, 8'h5A, 5, 1'b0, rd, miso_end);
        frame_close();
        ref_err_inc();
        check("abort wr pulses", 64'(wr_hi - w0), 64'd0);
        check("abort busy", 64'(busy_o), 64'd0);
        check("abort miso", 64'(miso_o), 64'd1);
        check_state("abort");
        frame_open();
        model_checked_txn("after abort", 8'h82, 8'h5A, 1'b0);
        frame_close();
        check("after abort reg2", 64'(regs_o[23:16]), 64'h5A);

        // Random frames of 1..3 transactions, mostly legal addresses.
        for (int f = 0; f < 10; f++) begin
            n_txn = int'($urandom_range(1, 3));
            frame_open();
            for (int t = 0; t < n_txn; t++) begin
                a = 8'($urandom);
                if ($urandom_range(0, 4) != 0) a[6:3] = 4'd0;
                d = 8'($urandom);
                model_checked_txn($sformatf("rnd%0d.%0d a=%02h", f, t, a), a, d, t != n_txn - 1);
            end
            frame_close();
        end

        // Asynchronous reset in the middle of a read's data phase.
        frame_open();
        txn(8'h03, 8'h00, 3, 1'b0, rd, miso_end);
        @(negedge pclk_i);
        #2 prst_i = 1'b0;
        #1;
        ref_reset();
        check("async rst regs", regs_o, 64'd0);
        check("async rst miso", 64'(miso_o), 64'd1);
        check("async rst busy", 64'(busy_o), 64'd0);
        check("async rst err_cnt", 64'(err_cnt_o), 64'd0);
        check("async rst wr_addr", 64'(wr_addr_o), 64'd0);
        ss_i = 1'b1;
        repeat (4) @(negedge pclk_i);
        prst_i = 1'b1;
        repeat (4) @(negedge pclk_i);
        frame_open();
        model_checked_txn("post rst wr", 8'h86, 8'h69, 1'b1);
        model_checked_txn("post rst rd", 8'h06, 8'h00, 1'b0);
        frame_close();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
